// File: rtl/sync_debounce_if.sv
// Signal bundle for sync_debounce: raw input plus synchronised/debounced results.
// No valid/ready handshake: d_async is sampled every clock, every output is a registered level or pulse.
`timescale 1ps/1ps

interface sync_debounce_if #(
    parameter int CNT_W = 8
);
    logic             d_async;
    logic             q_sync;
    logic             q_stable;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] glitch_cnt;
    logic             glitch_sat;
    logic             dbg_state;

    modport master (
        output d_async,
        input  q_sync, q_stable, rise, fall, glitch_cnt, glitch_sat, dbg_state
    );

    modport slave (
        input  d_async,
        output q_sync, q_stable, rise, fall, glitch_cnt, glitch_sat, dbg_state
    );
endinterface

// File: rtl/sync_debounce.sv
// N-flop synchroniser followed by a debounce FSM that emits rise/fall pulses
// and counts rejected glitches with a saturating counter.
`timescale 1ps/1ps

module sync_debounce #(
    parameter int   STAGES    = 2,
    parameter int   DEBOUNCE  = 4,
    parameter int   CNT_W     = 8,
    parameter logic RESET_VAL = 1'b0
) (
    input logic            clk,
    input logic            rst,
    sync_debounce_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] GCNT_MAX = '1;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [STAGES-1:0] sync;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic              q_stable;
    logic              rise;
    logic              fall;
    logic [CNT_W-1:0]  glitch_cnt;
    logic              glitch_sat;
    logic              q_sync;
    logic              mismatch;

    assign q_sync   = sync[STAGES-1];
    assign mismatch = q_sync ^ q_stable;

    // Only sync[0] ever sees the raw, possibly violating input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[STAGES-2:0], bus.d_async};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_STABLE;
            cnt        <= '0;
            q_stable   <= RESET_VAL;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= '0;
            glitch_sat <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    cnt <= '0;
                    if (mismatch) begin
                        if (DEBOUNCE == 1) begin
                            q_stable <= q_sync;
                            rise     <= q_sync;
                            fall     <= ~q_sync;
                        end else begin
                            state <= ST_CHECK;
                            cnt   <= CW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (cnt == CNT_LAST) begin
                            q_stable <= q_sync;
                            rise     <= q_sync;
                            fall     <= ~q_sync;
                            state    <= ST_STABLE;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        // Input returned before qualifying: a rejected glitch.
                        if (glitch_cnt != GCNT_MAX) begin
                            glitch_cnt <= glitch_cnt + CNT_W'(1);
                            glitch_sat <= (glitch_cnt == GCNT_MAX - CNT_W'(1));
                        end
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.q_sync     = q_sync;
    assign bus.q_stable   = q_stable;
    assign bus.rise       = rise;
    assign bus.fall       = fall;
    assign bus.glitch_cnt = glitch_cnt;
    assign bus.glitch_sat = glitch_sat;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default instance plus a CNT_W=2 instance for saturation.
`timescale 1ps/1ps

module tb_sync_debounce;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sync_debounce_if #(.CNT_W(8)) bus_a ();
    sync_debounce_if #(.CNT_W(2)) bus_b ();

    sync_debounce #(.STAGES(2), .DEBOUNCE(4), .CNT_W(8), .RESET_VAL(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sync_debounce #(.STAGES(2), .DEBOUNCE(4), .CNT_W(2), .RESET_VAL(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Clock / reset: 10ps period, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Advance one active edge and settle 1ps past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.d_async = 1'b0;
        bus_b.d_async = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            bus_a.d_async = ~bus_a.d_async;
            tick();
            n_checks++;
            if ({bus_a.q_sync, bus_a.q_stable, bus_a.rise, bus_a.fall, bus_a.glitch_sat} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outs: got %b expected 00000",
                         {bus_a.q_sync, bus_a.q_stable, bus_a.rise, bus_a.fall, bus_a.glitch_sat});
            end
            n_checks++;
            if (bus_a.glitch_cnt !== 8'd0 || bus_b.glitch_cnt !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_cnt: got %0h/%0h expected 0/0", bus_a.glitch_cnt, bus_b.glitch_cnt);
            end
        end
        bus_a.d_async = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({bus_a.q_stable, bus_a.rise, bus_a.fall, bus_a.dbg_state} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset: got %b expected 0000",
                     {bus_a.q_stable, bus_a.rise, bus_a.fall, bus_a.dbg_state});
        end
    endtask

    // Held step to 'lvl': q_sync at edge 1, q_stable and pulse at edge 5.
    task automatic test_step(input logic lvl);
        bus_a.d_async = lvl;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_checks++;
            if (bus_a.q_sync !== ((e >= 1) ? lvl : ~lvl)) begin
                n_fail++;
                $display("FAIL step_q_sync e%0d: got %b expected %b", e, bus_a.q_sync, (e >= 1) ? lvl : ~lvl);
            end
            n_checks++;
            if (bus_a.q_stable !== ((e >= 5) ? lvl : ~lvl)) begin
                n_fail++;
                $display("FAIL step_q_stable e%0d: got %b expected %b", e, bus_a.q_stable, (e >= 5) ? lvl : ~lvl);
            end
            n_checks++;
            if (bus_a.rise !== (lvl && e == 5) || bus_a.fall !== (!lvl && e == 5)) begin
                n_fail++;
                $display("FAIL step_pulse e%0d: got rise=%b fall=%b expected rise=%b fall=%b",
                         e, bus_a.rise, bus_a.fall, lvl && e == 5, !lvl && e == 5);
            end
        end
        n_checks++;
        if (bus_a.glitch_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL step_glitch_cnt: got %0d expected 0", bus_a.glitch_cnt);
        end
    endtask

    task automatic test_glitch(input int len, input int exp_cnt);
        bus_a.d_async = 1'b1;
        repeat (len) tick();
        bus_a.d_async = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_checks++;
            if (bus_a.q_stable !== 1'b0 || bus_a.rise !== 1'b0 || bus_a.fall !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch%0d_quiet e%0d: got q=%b r=%b f=%b expected 0 0 0",
                         len, e, bus_a.q_stable, bus_a.rise, bus_a.fall);
            end
        end
        n_checks++;
        if (bus_a.glitch_cnt !== 8'(exp_cnt) || bus_a.glitch_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch%0d_cnt: got %0d sat=%b expected %0d sat=0",
                     len, bus_a.glitch_cnt, bus_a.glitch_sat, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 5; i++) begin
            bus_b.d_async = 1'b1;
            tick();
            bus_b.d_async = 1'b0;
            repeat (6) tick();
            n_checks++;
            if (bus_b.glitch_cnt !== 2'((i < 3) ? i : 3) || bus_b.glitch_sat !== (i >= 3)) begin
                n_fail++;
                $display("FAIL sat_cnt g%0d: got %0d sat=%b expected %0d sat=%b",
                         i, bus_b.glitch_cnt, bus_b.glitch_sat, (i < 3) ? i : 3, i >= 3);
            end
            n_checks++;
            if (bus_b.q_stable !== 1'b0 || bus_b.rise !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_quiet g%0d: got q=%b r=%b expected 0 0", i, bus_b.q_stable, bus_b.rise);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        bus_a.d_async = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (bus_a.dbg_state !== 1'b1) begin
            n_fail++;
            $display("FAIL midchk_in_check: got %b expected 1", bus_a.dbg_state);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_a.q_sync, bus_a.q_stable, bus_a.rise, bus_a.dbg_state} !== 4'b0 || bus_a.glitch_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midchk_async_clear: got %b cnt=%0d expected 0000 cnt=0",
                     {bus_a.q_sync, bus_a.q_stable, bus_a.rise, bus_a.dbg_state}, bus_a.glitch_cnt);
        end
        for (int e = 0; e < 2; e++) begin
            tick();
            n_checks++;
            if (bus_a.rise !== 1'b0 || bus_a.q_stable !== 1'b0) begin
                n_fail++;
                $display("FAIL midchk_held e%0d: got r=%b q=%b expected 0 0", e, bus_a.rise, bus_a.q_stable);
            end
        end
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            n_checks++;
            if (bus_a.rise !== (e == 5) || bus_a.q_stable !== (e >= 5)) begin
                n_fail++;
                $display("FAIL midchk_release e%0d: got r=%b q=%b expected r=%b q=%b",
                         e, bus_a.rise, bus_a.q_stable, e == 5, e >= 5);
            end
        end
    endtask

    // Input changes 2ps before the active edge.
    task automatic test_violating();
        logic [3:0] levels;
        int rises;
        int falls;
        levels = 4'b1010;
        rises = 0;
        falls = 0;
        for (int k = 0; k < 4; k++) begin
            #7;
            bus_a.d_async = levels[k];
            for (int e = 0; e < 10; e++) begin
                tick();
                if (bus_a.rise === 1'b1) rises++;
                if (bus_a.fall === 1'b1) falls++;
                n_checks++;
                if ((bus_a.rise & bus_a.fall) !== 1'b0 || $isunknown({bus_a.q_sync, bus_a.q_stable})) begin
                    n_fail++;
                    $display("FAIL viol_sanity k%0d e%0d: got r=%b f=%b qs=%b q=%b expected clean, not both",
                             k, e, bus_a.rise, bus_a.fall, bus_a.q_sync, bus_a.q_stable);
                end
                if (e == 5) begin
                    n_checks++;
                    if (bus_a.q_stable !== levels[k]) begin
                        n_fail++;
                        $display("FAIL viol_settle k%0d: got %b expected %b", k, bus_a.q_stable, levels[k]);
                    end
                end
            end
        end
        n_checks++;
        if (rises != 2 || falls != 2) begin
            n_fail++;
            $display("FAIL viol_pulses: got rises=%0d falls=%0d expected 2 2", rises, falls);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_step(1'b1);
        test_step(1'b0);
        test_glitch(2, 1);
        test_glitch(3, 2);
        test_glitch(1, 3);
        test_saturation();
        test_reset_mid_check();
        test_violating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
